// File: rtl/dvi_channel_decoder.sv
// One TMDS receive channel: aligns the deserializer word boundary with bit-slips
// until control-token runs are seen, then decodes symbols to pixel data or control.
`timescale 1ns/1ps

module dvi_channel_decoder #(
  parameter int SEARCH_WINDOW = 4096,
  parameter int CTRL_RUN      = 8,
  parameter int SLIP_WAIT     = 4
) (
  input  logic       i_pix_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_tmds,
  output logic       o_bitslip,
  output logic       o_aligned,
  output logic       o_de,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl
);

  // state     | meaning
  // ST_SEARCH | looking for a token run within the window
  // ST_SLIP   | one-cycle bit-slip request
  // ST_WAIT   | deserializer settling after a slip
  // ST_LOCKED | aligned; watchdog refreshed by saturated token runs
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SLIP   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [WIN_W-1:0] WAIT_LAST = WIN_W'(SLIP_WAIT - 1);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(CTRL_RUN);

  logic [9:0]       tmds_q;
  logic [1:0]       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             bitslip_q, aligned_q, de_q;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             de_d, locked_d;

  logic             is_tok;
  logic [1:0]       tok_val;
  logic [7:0]       dec_in, dec_data;

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (tmds_q)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: is_tok  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    dec_in      = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
    dec_data    = 8'h00;
    dec_data[0] = dec_in[0];
    for (int i = 1; i < 8; i++) begin
      dec_data[i] = tmds_q[8] ? (dec_in[i] ^ dec_in[i-1]) : ~(dec_in[i] ^ dec_in[i-1]);
    end
  end

  always_comb begin
    if (state_q == ST_WAIT) begin
      run_d = '0;
    end else if (is_tok) begin
      run_d = (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
    end else begin
      run_d = '0;
    end
  end

  // The window counter doubles as the settle timer in WAIT and the watchdog in LOCKED.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      ST_SEARCH: begin
        win_d = win_q + WIN_W'(1);
        if (run_d == RUN_SAT) begin
          state_d = ST_LOCKED;
          win_d   = '0;
        end else if (win_q == WIN_LAST) begin
          state_d = ST_SLIP;
          win_d   = '0;
        end
      end
      ST_SLIP: begin
        state_d = ST_WAIT;
        win_d   = '0;
      end
      ST_WAIT: begin
        win_d = win_q + WIN_W'(1);
        if (win_q == WAIT_LAST) begin
          state_d = ST_SEARCH;
          win_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (run_q == RUN_SAT && is_tok) begin
          win_d = '0;
        end else if (win_q == WIN_LAST) begin
          state_d = ST_SEARCH;
          win_d   = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      default: begin
        state_d = ST_SEARCH;
        win_d   = '0;
      end
    endcase
  end

  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    de_d     = locked_d && !is_tok;
    data_d   = de_d ? dec_data : 8'h00;
    if (!locked_d) begin
      ctrl_d = 2'b00;
    end else if (is_tok) begin
      ctrl_d = tok_val;
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmds_q    <= '0;
      state_q   <= ST_SEARCH;
      win_q     <= '0;
      run_q     <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      de_q      <= 1'b0;
      data_q    <= 8'h00;
      ctrl_q    <= 2'b00;
    end else begin
      tmds_q    <= i_tmds;
      state_q   <= state_d;
      win_q     <= win_d;
      run_q     <= run_d;
      bitslip_q <= (state_d == ST_SLIP);
      aligned_q <= locked_d;
      de_q      <= de_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign o_bitslip = bitslip_q;
  assign o_aligned = aligned_q;
  assign o_de      = de_q;
  assign o_data    = data_q;
  assign o_ctrl    = ctrl_q;

endmodule

// File: tb/tb_dvi_channel_decoder.sv
// Bench for dvi_channel_decoder: scoreboard of expected outputs, a TMDS encoder
// and a bit-rotating deserializer model for the alignment search.
`timescale 1ns/1ps

module tb_dvi_channel_decoder;

  localparam int LINE_LEN = 1650;
  localparam int ACTIVE   = 1280;
  localparam int SLIP_GAP = 4096 + 1 + 4;

  logic       i_pix_clk = 1'b0;
  logic       i_rst_n   = 1'b0;
  logic [9:0] i_tmds    = 10'h000;
  logic       o_bitslip, o_aligned, o_de;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;

  dvi_channel_decoder #(.SEARCH_WINDOW(4096), .CTRL_RUN(8), .SLIP_WAIT(4)) dut (
    .i_pix_clk (i_pix_clk),
    .i_rst_n   (i_rst_n),
    .i_tmds    (i_tmds),
    .o_bitslip (o_bitslip),
    .o_aligned (o_aligned),
    .o_de      (o_de),
    .o_data    (o_data),
    .o_ctrl    (o_ctrl)
  );

  always #5 i_pix_clk = ~i_pix_clk;

  typedef struct {
    longint     due;
    logic       al;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  exp_t       sb[$];
  longint     cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [9:0] line_w  [LINE_LEN];
  logic [7:0] line_px [LINE_LEN];

  always @(posedge i_pix_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic inv);
    int         n1;
    logic       xn;
    logic [8:0] qm;
    n1    = $countones(d);
    xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  // Word k of the serial line stream taken at bit offset 'off'.
  function automatic logic [9:0] des_word(input longint k, input int off);
    logic [9:0] w;
    logic [9:0] src;
    longint     idx;
    w = '0;
    for (int b = 0; b < 10; b++) begin
      idx  = k * 10 + longint'(off) + longint'(b);
      src  = line_w[int'((idx / 10) % LINE_LEN)];
      w[b] = src[int'(idx % 10)];
    end
    return w;
  endfunction

  task automatic drive(input logic [9:0] w, input logic chk, input logic al, input logic de,
                       input logic [7:0] data, input logic [1:0] ctrl);
    exp_t e;
    @(posedge i_pix_clk);
    #1;
    i_tmds = w;
    if (chk) begin
      e.due  = cyc + 2;
      e.al   = al;
      e.de   = de;
      e.data = data;
      e.ctrl = ctrl;
      sb.push_back(e);
    end
  endtask

  task automatic drain_and_reset();
    repeat (3) @(posedge i_pix_clk);
    sb.delete();
    i_tmds = 10'h000;
    #3;
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_pix_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_bitslip"}, 32'(o_bitslip), 32'd0);
    check_eq({tag, "_aligned"}, 32'(o_aligned), 32'd0);
    check_eq({tag, "_de"},      32'(o_de),      32'd0);
    check_eq({tag, "_data"},    32'(o_data),    32'd0);
    check_eq({tag, "_ctrl"},    32'(o_ctrl),    32'd0);
  endtask

  initial begin : sb_checker
    exp_t e;
    forever begin
      @(posedge i_pix_clk);
      #2;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check_eq("sb_due",     32'(cyc - e.due), 32'd0);
        check_eq("sb_aligned", 32'(o_aligned),   32'(e.al));
        check_eq("sb_de",      32'(o_de),        32'(e.de));
        check_eq("sb_data",    32'(o_data),      32'(e.data));
        check_eq("sb_ctrl",    32'(o_ctrl),      32'(e.ctrl));
        check_eq("sb_bitslip", 32'(o_bitslip),   32'd0);
      end
    end
  end

  initial begin : timeout
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    int     off;
    int     n_bs;
    longint last_bs;
    logic   prev_bs;
    longint k;
    int     j;
    logic [9:0] w;

    for (int n = 0; n < LINE_LEN; n++) begin
      line_px[n] = 8'((n * 37 + 11) & 255);
      if (n < ACTIVE) begin
        w = tmds_enc(line_px[n], n[0]);
        if (is_token(w)) w = tmds_enc(line_px[n], ~n[0]);
        line_w[n] = w;
      end else begin
        line_w[n] = 10'h354;
      end
    end

    // Reset state
    repeat (3) @(posedge i_pix_clk);
    #1;
    check_all_zero("reset");
    i_rst_n = 1'b1;

    // Aligned decode: lock on the 8th token
    for (int n = 0; n < 12; n++) drive(10'h354, 1'b1, n >= 7, 1'b0, 8'h00, 2'b00);
    drive(10'h100, 1'b1, 1'b1, 1'b1, 8'h00, 2'b00);
    drive(10'h200, 1'b1, 1'b1, 1'b1, 8'hFF, 2'b00);
    drive(10'h0AB, 1'b1, 1'b1, 1'b0, 8'h00, 2'b01);

    // Token mapping while locked; data holds the last control value
    drive(10'h354, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00);
    drive(10'h0AB, 1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
    drive(10'h154, 1'b1, 1'b1, 1'b0, 8'h00, 2'b10);
    drive(10'h2AB, 1'b1, 1'b1, 1'b0, 8'h00, 2'b11);
    drive(10'h100, 1'b1, 1'b1, 1'b1, 8'h00, 2'b11);
    drive(10'h200, 1'b1, 1'b1, 1'b1, 8'hFF, 2'b11);

    // Watchdog: 4096 data words drop lock on the last one, no slip
    for (int n = 0; n < 10; n++) drive(10'h354, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00);
    for (int n = 1; n <= 4096; n++) begin
      if (n < 4096) drive(10'h100, 1'b1, 1'b1, 1'b1, 8'h00, 2'b00);
      else          drive(10'h100, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
    end
    for (int n = 0; n < 4; n++) drive(10'h100, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
    for (int n = 0; n < 10; n++) drive(10'h354, 1'b1, n >= 7, 1'b0, 8'h00, 2'b00);

    // Lock and window expiry in the same cycle: lock wins
    drain_and_reset();
    for (int n = 1; n <= 4086; n++) drive(10'h000, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
    for (int n = 0; n < 8; n++) drive(10'h354, 1'b1, n == 7, 1'b0, 8'h00, 2'b00);
    for (int n = 0; n < 4; n++) drive(10'h0AB, 1'b1, 1'b1, 1'b0, 8'h00, 2'b01);

    // Async reset between edges while locked
    repeat (3) @(posedge i_pix_clk);
    sb.delete();
    check_eq("pre_reset_aligned", 32'(o_aligned), 32'd1);
    check_eq("pre_reset_ctrl",    32'(o_ctrl),    32'd1);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    i_tmds = 10'h000;
    repeat (2) @(posedge i_pix_clk);
    #1;
    i_rst_n = 1'b1;
    for (int n = 0; n < 10; n++) drive(10'h154, 1'b1, n >= 7, 1'b0, 8'h00, n >= 7 ? 2'b10 : 2'b00);

    // Misaligned stream: rotated by 3 bits, one bit per slip request
    drain_and_reset();
    off     = 3;
    n_bs    = 0;
    last_bs = 0;
    prev_bs = 1'b0;
    k       = 0;
    for (int c = 0; c < 40000 && o_aligned !== 1'b1; c++) begin
      @(posedge i_pix_clk);
      #1;
      if (o_bitslip === 1'b1) begin
        check_eq("bs_width", 32'(prev_bs), 32'd0);
        if (n_bs > 0) check_eq("bs_gap", 32'(cyc - last_bs), 32'(SLIP_GAP));
        last_bs = cyc;
        n_bs++;
        off++;
      end
      prev_bs = o_bitslip;
      i_tmds  = des_word(k, off);
      k++;
    end
    check_eq("lock_found", 32'(o_aligned), 32'd1);
    check_eq("bs_count",   32'(n_bs),      32'd7);
    check_eq("lock_phase", 32'(off % 10),  32'd0);
    for (int n = 0; n < LINE_LEN; n++) begin
      j = int'(((k * 10 + longint'(off)) / 10) % LINE_LEN);
      if (j < ACTIVE) drive(des_word(k, off), 1'b1, 1'b1, 1'b1, line_px[j], 2'b00);
      else            drive(des_word(k, off), 1'b1, 1'b1, 1'b0, 8'h00, 2'b00);
      k++;
    end

    repeat (4) @(posedge i_pix_clk);
    #3;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
